move_selector: RTL and testbench

//  Player-input front end for the tic-tac-toe board. Debounces three buttons, moves a 0..8 cursor and

---
 rtl/move_selector_if.sv | 23 ++
 rtl/move_selector.sv | 139 +++++++++++++
 tb/tb_move_selector.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/move_selector_if.sv
// rtl/move_selector_if.sv - button/board/strobe bundle between the board controller and move_selector
interface move_selector_if;
    logic       new_game;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_sel;
    logic [8:0] occupied;
    logic       game_over;
    logic [3:0] pos;
    logic       place_en;
    logic       player;
    logic       invalid;

    modport master (
        output new_game, btn_next, btn_prev, btn_sel, occupied, game_over,
        input  pos, place_en, player, invalid
    );

    modport slave (
        input  new_game, btn_next, btn_prev, btn_sel, occupied, game_over,
        output pos, place_en, player, invalid
    );
endinterface

// File: rtl/move_selector.sv
// rtl/move_selector.sv - debounced cursor, placement validation and turn tracking (optional AUTO_SKIP_EN)
module move_selector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NUM_CELLS       = 9
) (
    input  logic           clk,
    input  logic           rst,
    move_selector_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [3:0] LAST_CELL = 4'(NUM_CELLS - 1);

    typedef enum logic [1:0] {SELECT, COMMIT, SETTLE} state_t;

    state_t              state_q;
    logic [3:0]          pos_q;
    logic                player_q;
    logic                place_en_q;
    logic                invalid_q;
    logic [2:0][CW-1:0]  cnt_q;
    logic [2:0]          lvl_q;
    logic [2:0]          raw;
    logic [2:0]          lvl;
    logic [2:0]          ev;
    logic [3:0]          pos_fwd;
    logic [3:0]          pos_bwd;
    logic                clear;

    assign clear = rst | bus.new_game;
    assign raw   = {bus.btn_sel, bus.btn_prev, bus.btn_next};

    // Debounced level is a saturated counter; an event is its rising edge
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            lvl[i] = (cnt_q[i] == DB_MAX);
        end
        ev = lvl & ~lvl_q;
    end

    // Per-button saturating debounce counters and previous-level history
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
            lvl_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!raw[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] != DB_MAX) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
            lvl_q <= lvl;
        end
    end

`ifdef AUTO_SKIP_EN
    logic [4:0] idx_f;
    logic [4:0] idx_b;
    logic       found_f;
    logic       found_b;

    // Nearest free cell in each direction, wrapping; stay put when none exists
    always_comb begin
        pos_fwd = pos_q;
        pos_bwd = pos_q;
        found_f = 1'b0;
        found_b = 1'b0;
        idx_f   = '0;
        idx_b   = '0;
        for (int k = 1; k < NUM_CELLS; k++) begin
            idx_f = 5'(pos_q) + 5'(k);
            if (idx_f >= 5'(NUM_CELLS)) idx_f = idx_f - 5'(NUM_CELLS);
            idx_b = 5'(pos_q) + 5'(NUM_CELLS - k);
            if (idx_b >= 5'(NUM_CELLS)) idx_b = idx_b - 5'(NUM_CELLS);
            if (!found_f && !bus.occupied[idx_f[3:0]]) begin
                pos_fwd = idx_f[3:0];
                found_f = 1'b1;
            end
            if (!found_b && !bus.occupied[idx_b[3:0]]) begin
                pos_bwd = idx_b[3:0];
                found_b = 1'b1;
            end
        end
    end
`else
    // Plain single-step wrap in each direction
    always_comb begin
        pos_fwd = (pos_q == LAST_CELL) ? 4'd0 : pos_q + 4'd1;
        pos_bwd = (pos_q == 4'd0) ? LAST_CELL : pos_q - 4'd1;
    end
`endif

    // Select/commit/settle sequencer with registered strobes
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= SELECT;
            pos_q      <= 4'd0;
            player_q   <= 1'b0;
            place_en_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            place_en_q <= 1'b0;
            invalid_q  <= 1'b0;
            case (state_q)
                SELECT: begin
                    if (ev[2]) begin
                        if (bus.occupied[pos_q] || bus.game_over) begin
                            invalid_q <= 1'b1;
                        end else begin
                            place_en_q <= 1'b1;
                            state_q    <= COMMIT;
                        end
                    end else if (ev[0] && !ev[1]) begin
                        pos_q <= pos_fwd;
                    end else if (ev[1] && !ev[0]) begin
                        pos_q <= pos_bwd;
                    end
                end
                COMMIT: begin
                    player_q <= ~player_q;
                    state_q  <= SETTLE;
                end
                SETTLE: begin
                    state_q <= SELECT;
                end
                default: begin
                    state_q <= SELECT;
                end
            endcase
        end
    end

    assign bus.pos      = pos_q;
    assign bus.place_en = place_en_q;
    assign bus.player   = player_q;
    assign bus.invalid  = invalid_q;
endmodule

// File: tb/tb_move_selector.sv
// tb/tb_move_selector.sv - directed and random checks of move_selector against a rule-level model
module tb_move_selector;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    move_selector_if bus();

    move_selector #(.DEBOUNCE_CYCLES(DB), .NUM_CELLS(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int m_pos = 0;
    int m_player = 0;
    int n_pe, n_inv, n_both, pe_pos, bad_pos;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.place_en === 1'b1) begin
            n_pe++;
            pe_pos = int'(bus.pos);
        end
        if (bus.invalid === 1'b1) n_inv++;
        if (bus.place_en === 1'b1 && bus.invalid === 1'b1) n_both++;
        if (bus.pos > 4'd8) bad_pos++;
    endtask

    function automatic int ref_step(input int p, input bit fwd, input logic [8:0] occ);
`ifdef AUTO_SKIP_EN
        for (int k = 1; k < 9; k++) begin
            int c;
            c = fwd ? (p + k) % 9 : (p - k + 9) % 9;
            if (!occ[c]) return c;
        end
        return p;
`else
        return fwd ? (p + 1) % 9 : (p + 8) % 9;
`endif
    endfunction

    task automatic press(input bit nx, input bit pv, input bit sl, input int hold, input string tag);
        int exp_pe, exp_inv, exp_pepos;
        exp_pe = 0; exp_inv = 0; exp_pepos = -1;
        n_pe = 0; n_inv = 0; n_both = 0; pe_pos = -1; bad_pos = 0;
        bus.btn_next = nx; bus.btn_prev = pv; bus.btn_sel = sl;
        repeat (hold) tick();
        bus.btn_next = 1'b0; bus.btn_prev = 1'b0; bus.btn_sel = 1'b0;
        repeat (5) tick();
        if (hold >= DB) begin
            if (sl) begin
                if (bus.occupied[m_pos] || bus.game_over) begin
                    exp_inv = 1;
                end else begin
                    exp_pe = 1;
                    exp_pepos = m_pos;
                    m_player ^= 1;
                end
            end else if (nx != pv) begin
                m_pos = ref_step(m_pos, nx, bus.occupied);
            end
        end
        check({tag, "_pos"}, int'(bus.pos), m_pos);
        check({tag, "_player"}, int'(bus.player), m_player);
        check({tag, "_place_en_count"}, n_pe, exp_pe);
        check({tag, "_invalid_count"}, n_inv, exp_inv);
        check({tag, "_commit_pos"}, pe_pos, exp_pepos);
        check({tag, "_exclusive"}, n_both, 0);
        check({tag, "_pos_range"}, bad_pos, 0);
    endtask

    task automatic goto_cell(input int target);
        bus.occupied = 9'h000;
        for (int i = 0; i < 9 && m_pos != target; i++) press(1'b1, 1'b0, 1'b0, DB, "goto");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t;
        int exp_a, exp_b;
        rst = 1'b1;
        bus.new_game = 1'b0; bus.btn_next = 1'b0; bus.btn_prev = 1'b0; bus.btn_sel = 1'b0;
        bus.occupied = 9'h000; bus.game_over = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("reset_pos", int'(bus.pos), 0);
        check("reset_player", int'(bus.player), 0);
        check("reset_place_en", int'(bus.place_en), 0);
        check("reset_invalid", int'(bus.invalid), 0);

        // debounce thresholds
        press(1'b1, 1'b0, 1'b0, DB - 1, "t1_short");
        press(1'b1, 1'b0, 1'b0, DB, "t1_exact");
        press(1'b1, 1'b0, 1'b0, 50, "t1_held");

        // wrap and simultaneous next/prev
        goto_cell(8);
        press(1'b1, 1'b0, 1'b0, DB, "t2_wrap_fwd");
        press(1'b0, 1'b1, 1'b0, DB, "t2_wrap_bwd");
        press(1'b1, 1'b1, 1'b0, DB + 2, "t2_both");

        // valid commit
        goto_cell(4);
        press(1'b0, 1'b0, 1'b1, DB, "t3_commit");

        // rejected selects
        bus.occupied = 9'h010;
        press(1'b0, 1'b0, 1'b1, DB, "t4_occupied");
        bus.occupied = 9'h000;
        bus.game_over = 1'b1;
        press(1'b0, 1'b0, 1'b1, DB, "t4_game_over");
        press(1'b1, 1'b0, 1'b0, DB, "t4_nav_while_over");
        bus.game_over = 1'b0;

        // reset during COMMIT
        bus.btn_sel = 1'b1;
        t = 0;
        while (bus.place_en !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        check("t5_commit_seen", int'(bus.place_en), 1);
        rst = 1'b1;
        bus.btn_sel = 1'b0;
        tick();
        check("t5_rst_place_en", int'(bus.place_en), 0);
        check("t5_rst_pos", int'(bus.pos), 0);
        check("t5_rst_player", int'(bus.player), 0);
        rst = 1'b0;
        m_pos = 0; m_player = 0;
        repeat (3) tick();

        // new_game mid-play
        goto_cell(5);
        press(1'b0, 1'b0, 1'b1, DB, "t5_pre_new_game");
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        check("t5_ng_pos", int'(bus.pos), 0);
        check("t5_ng_player", int'(bus.player), 0);
        check("t5_ng_place_en", int'(bus.place_en), 0);
        m_pos = 0; m_player = 0;
        repeat (2) tick();

        // skip behaviour (or plain stepping without the option)
`ifdef AUTO_SKIP_EN
        exp_a = 3; exp_b = 0;
`else
        exp_a = 1; exp_b = 1;
`endif
        bus.occupied = 9'h006;
        press(1'b1, 1'b0, 1'b0, DB, "t6_skip");
        check("t6_skip_const", int'(bus.pos), exp_a);
        goto_cell(0);
        bus.occupied = 9'h1FE;
        press(1'b1, 1'b0, 1'b0, DB, "t6_full");
        check("t6_full_const", int'(bus.pos), exp_b);
        bus.occupied = 9'h000;

        // random presses
        for (int i = 0; i < 40; i++) begin
            logic [2:0] b;
            bus.occupied = 9'($urandom);
            bus.game_over = ($urandom_range(0, 7) == 0);
            b = 3'($urandom);
            press(b[0], b[1], b[2], $urandom_range(DB - 2, DB + 6), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
